// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg: shared state encoding and default width for the countdown timer
package countdown_timer_pkg;
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
    localparam int TIMER_WIDTH_DEFAULT = 4;
endpackage

// File: rtl/decrement_nbit.sv
// decrement_nbit: ripple decrementer, s = a - 1 computed as a + ~1 + 1 so carry-out flags a != 0
module decrement_nbit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] s,
    output logic             ca_out
);
    localparam logic [WIDTH-1:0] B = {{(WIDTH-1){1'b1}}, 1'b0};
    logic [WIDTH:0] c;
    assign c[0]   = 1'b1;
    assign ca_out = c[WIDTH];
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_fa
            fulladder1 u_fa (
                .a    (a[i]),
                .b    (B[i]),
                .c_in (c[i]),
                .s    (s[i]),
                .c_out(c[i+1])
            );
        end
    endgenerate
endmodule

// File: rtl/fulladder1.sv
// fulladder1: single-bit full adder cell
module fulladder1 (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable, pausable countdown with start/busy/done handshake and auto-reload
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             pause,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    state_t           state, state_nx;
    logic [WIDTH-1:0] reload_reg, reload_nx, count_nx, dec;
    logic             done_nx, dec_commit, ca_out;

    decrement_nbit #(.WIDTH(WIDTH)) u_dec (
        .a     (count),
        .s     (dec),
        .ca_out(ca_out)
    );

    // next-state selection: restart beats pause, pause beats terminal, terminal beats decrement
    always_comb begin
        state_nx   = state;
        count_nx   = count;
        reload_nx  = reload_reg;
        done_nx    = 1'b0;
        dec_commit = 1'b0;
        if (start) begin
            count_nx  = load_val;
            reload_nx = load_val;
            done_nx   = (load_val == '0);
            state_nx  = (load_val == '0) ? ST_IDLE : ST_RUN;
        end else if (state == ST_RUN && !pause) begin
            if (count == ONE) begin
                done_nx  = 1'b1;
                count_nx = auto_reload ? reload_reg : '0;
                state_nx = auto_reload ? ST_RUN : ST_IDLE;
            end else begin
                count_nx   = dec;
                dec_commit = 1'b1;
            end
        end
    end

    // state, count, captured reload value and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            count      <= '0;
            reload_reg <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            count      <= count_nx;
            reload_reg <= reload_nx;
            busy       <= (state_nx == ST_RUN);
            done       <= done_nx;
        end
    end

    // a committed decrement must never see a zero count
    always @(posedge clk) begin
        if (rst_n && dec_commit) assert (ca_out);
    end
endmodule
